// File: rtl/axis_byte_realign_if.sv
// AXI4-Stream bundle (data, byte keep, valid/ready, last) shared by the realigner's input and output.
interface axis_byte_realign_if #(
  parameter int DATA_BYTES = 4
);
  logic [8*DATA_BYTES-1:0] tdata;
  logic [DATA_BYTES-1:0]   tkeep;
  logic                    tvalid;
  logic                    tready;
  logic                    tlast;

  modport master (output tdata, output tkeep, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tkeep, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_byte_realign.sv
// Strips the first S bytes of each packet and repacks the rest onto lane 0; registered output,
// one beat of latency (S=0) or one beat behind the input (S>0); input stalls while output is blocked.
module axis_byte_realign #(
  parameter int  DATA_BYTES = 4,
  parameter int  MAX_SHIFT  = 3,
  localparam int SHW        = $clog2(MAX_SHIFT + 1)
) (
  input  logic                  aclk,
  input  logic                  ARESETn,
  input  logic [SHW-1:0]        cfg_shift,
  axis_byte_realign_if.slave    s_axis,
  axis_byte_realign_if.master   m_axis,
  output logic                  runt_drop,
  output logic [15:0]           pkt_cnt
);
  localparam int DW = 8 * DATA_BYTES;

  typedef enum logic [1:0] {ST_FIRST, ST_MID, ST_FLUSH} state_t;

  state_t                state_q, state_d;
  logic [DW-1:0]         hold_dat_q, hold_dat_d;
  logic [DATA_BYTES-1:0] hold_keep_q, hold_keep_d;
  logic [SHW-1:0]        shift_q, shift_d;
  logic [DW-1:0]         m_dat_q, m_dat_d;
  logic [DATA_BYTES-1:0] m_keep_q, m_keep_d;
  logic                  m_vld_q, m_vld_d;
  logic                  m_last_q, m_last_d;
  logic                  runt_q, runt_d;
  logic [15:0]           pkt_cnt_q, pkt_cnt_d;

  logic                  out_free;
  logic                  s_rdy;
  logic                  s_acc;
  logic [SHW-1:0]        s_new;
  logic [DW-1:0]         in_dat;

  function automatic logic [DW-1:0] sh_dat(input logic [DW-1:0] x, input logic [SHW-1:0] s);
    return x >> (8 * int'(s));
  endfunction

  function automatic logic [DW-1:0] up_dat(input logic [DW-1:0] x, input logic [SHW-1:0] s);
    return x << (8 * (DATA_BYTES - int'(s)));
  endfunction

  function automatic logic [DATA_BYTES-1:0] sh_keep(input logic [DATA_BYTES-1:0] x,
                                                   input logic [SHW-1:0] s);
    return x >> int'(s);
  endfunction

  function automatic logic [DATA_BYTES-1:0] up_keep(input logic [DATA_BYTES-1:0] x,
                                                   input logic [SHW-1:0] s);
    return x << (DATA_BYTES - int'(s));
  endfunction

  assign out_free      = !m_vld_q || m_axis.tready;
  assign s_rdy         = (state_q != ST_FLUSH) && out_free;
  assign s_acc         = s_axis.tvalid && s_rdy;
  assign s_new         = (int'(cfg_shift) > MAX_SHIFT) ? SHW'(MAX_SHIFT) : cfg_shift;

  assign s_axis.tready = s_rdy;
  assign m_axis.tdata  = m_dat_q;
  assign m_axis.tkeep  = m_keep_q;
  assign m_axis.tvalid = m_vld_q;
  assign m_axis.tlast  = m_last_q;
  assign runt_drop     = runt_q;
  assign pkt_cnt       = pkt_cnt_q;

  // Invalid input lanes are zeroed so they can never leak into kept output lanes.
  always_comb begin
    in_dat = '0;
    for (int i = 0; i < DATA_BYTES; i++) begin
      if (s_axis.tkeep[i]) in_dat[8*i +: 8] = s_axis.tdata[8*i +: 8];
    end
  end

  always_comb begin
    state_d     = state_q;
    hold_dat_d  = hold_dat_q;
    hold_keep_d = hold_keep_q;
    shift_d     = shift_q;
    m_dat_d     = m_dat_q;
    m_keep_d    = m_keep_q;
    m_last_d    = m_last_q;
    m_vld_d     = out_free ? 1'b0 : m_vld_q;
    runt_d      = 1'b0;
    pkt_cnt_d   = pkt_cnt_q + ((m_vld_q && m_axis.tready && m_last_q) ? 16'd1 : 16'd0);

    unique case (state_q)
      ST_FIRST: begin
        if (s_acc) begin
          shift_d     = s_new;
          hold_dat_d  = in_dat;
          hold_keep_d = s_axis.tkeep;
          if (s_new == '0) begin
            m_vld_d  = 1'b1;
            m_dat_d  = in_dat;
            m_keep_d = s_axis.tkeep;
            m_last_d = s_axis.tlast;
            if (!s_axis.tlast) state_d = ST_MID;
          end else if (!s_axis.tlast) begin
            state_d = ST_MID;
          end else if (sh_keep(s_axis.tkeep, s_new) != '0) begin
            m_vld_d  = 1'b1;
            m_dat_d  = sh_dat(in_dat, s_new);
            m_keep_d = sh_keep(s_axis.tkeep, s_new);
            m_last_d = 1'b1;
          end else begin
            runt_d = 1'b1;
          end
        end
      end
      ST_MID: begin
        if (s_acc) begin
          hold_dat_d  = in_dat;
          hold_keep_d = s_axis.tkeep;
          m_vld_d     = 1'b1;
          if (shift_q == '0) begin
            m_dat_d  = in_dat;
            m_keep_d = s_axis.tkeep;
            m_last_d = s_axis.tlast;
            if (s_axis.tlast) state_d = ST_FIRST;
          end else begin
            m_dat_d  = sh_dat(hold_dat_q, shift_q) | up_dat(in_dat, shift_q);
            m_keep_d = sh_keep(hold_keep_q, shift_q) | up_keep(s_axis.tkeep, shift_q);
            m_last_d = 1'b0;
            // Last beat short enough to fit entirely in this output: no flush needed.
            if (s_axis.tlast) begin
              if (sh_keep(s_axis.tkeep, shift_q) == '0) begin
                m_last_d = 1'b1;
                state_d  = ST_FIRST;
              end else begin
                state_d = ST_FLUSH;
              end
            end
          end
        end
      end
      ST_FLUSH: begin
        if (out_free) begin
          m_vld_d  = 1'b1;
          m_dat_d  = sh_dat(hold_dat_q, shift_q);
          m_keep_d = sh_keep(hold_keep_q, shift_q);
          m_last_d = 1'b1;
          state_d  = ST_FIRST;
        end
      end
      default: state_d = ST_FIRST;
    endcase
  end

  always_ff @(posedge aclk or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q     <= ST_FIRST;
      hold_dat_q  <= '0;
      hold_keep_q <= '0;
      shift_q     <= '0;
      m_dat_q     <= '0;
      m_keep_q    <= '0;
      m_vld_q     <= 1'b0;
      m_last_q    <= 1'b0;
      runt_q      <= 1'b0;
      pkt_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      hold_dat_q  <= hold_dat_d;
      hold_keep_q <= hold_keep_d;
      shift_q     <= shift_d;
      m_dat_q     <= m_dat_d;
      m_keep_q    <= m_keep_d;
      m_vld_q     <= m_vld_d;
      m_last_q    <= m_last_d;
      runt_q      <= runt_d;
      pkt_cnt_q   <= pkt_cnt_d;
    end
  end
endmodule

// File: tb/tb_axis_byte_realign.sv
// Bench for axis_byte_realign: byte-queue reference model, random data and output backpressure.
module tb_axis_byte_realign;
  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } beat_t;

  logic        aclk;
  logic        ARESETn;
  logic [1:0]  cfg_shift;
  logic        runt_drop;
  logic [15:0] pkt_cnt;

  axis_byte_realign_if #(.DATA_BYTES(4)) s_if ();
  axis_byte_realign_if #(.DATA_BYTES(4)) m_if ();

  axis_byte_realign #(.DATA_BYTES(4), .MAX_SHIFT(3)) dut (
    .aclk      (aclk),
    .ARESETn   (ARESETn),
    .cfg_shift (cfg_shift),
    .s_axis    (s_if),
    .m_axis    (m_if),
    .runt_drop (runt_drop),
    .pkt_cnt   (pkt_cnt)
  );

  beat_t got_q[$];
  beat_t exp_q[$];
  int    total, bad;
  int    runt_seen, exp_runt, stab_err, rdy_err, to_cnt, cyc, exp_cnt;
  int    acc_first, acc_last;
  bit    rand_mode;
  bit    stall_q;
  beat_t stall_beat;

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  always @(posedge aclk) cyc <= cyc + 1;

  initial begin
    m_if.tready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      m_if.tready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output collector plus protocol watchers; the tests judge the counters it keeps.
  always @(negedge aclk) begin
    if (ARESETn) begin
      if (m_if.tvalid && m_if.tready) got_q.push_back({m_if.tdata, m_if.tkeep, m_if.tlast});
      if (runt_drop) runt_seen++;
      if (stall_q && (!m_if.tvalid || {m_if.tdata, m_if.tkeep, m_if.tlast} != stall_beat))
        stab_err++;
      if (m_if.tvalid && !m_if.tready && s_if.tready) rdy_err++;
      stall_q    = m_if.tvalid && !m_if.tready;
      stall_beat = {m_if.tdata, m_if.tkeep, m_if.tlast};
      if (s_if.tvalid)
        assert (s_if.tlast ? (s_if.tkeep != 4'h0 && ((int'(s_if.tkeep) + 1) & int'(s_if.tkeep)) == 0)
                           : (s_if.tkeep == 4'hF))
        else $error("illegal input tkeep %h", s_if.tkeep);
    end else begin
      stall_q = 1'b0;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  function automatic void model_pkt(input logic [7:0] b[$], input int s);
    int    se;
    int    rem;
    beat_t bt;
    se  = (s > 3) ? 3 : s;
    rem = b.size() - se;
    if (rem <= 0) begin
      exp_runt++;
      return;
    end
    for (int i = 0; i < rem; i += 4) begin
      bt = '0;
      for (int j = 0; j < 4 && i + j < rem; j++) begin
        bt.d[8*j +: 8] = b[se + i + j];
        bt.k[j]        = 1'b1;
      end
      bt.l = (i + 4 >= rem);
      exp_q.push_back(bt);
    end
    exp_cnt++;
  endfunction

  task automatic send_pkt(input logic [7:0] b[$], input logic [1:0] c0, input logic [1:0] c1);
    int   n;
    int   nb;
    int   idx;
    bit   acc;
    n  = b.size();
    nb = (n + 3) / 4;
    for (int i = 0; i < nb; i++) begin
      s_if.tdata  = '0;
      s_if.tkeep  = '0;
      for (int j = 0; j < 4; j++) begin
        idx = i * 4 + j;
        if (idx < n) begin
          s_if.tdata[8*j +: 8] = b[idx];
          s_if.tkeep[j]        = 1'b1;
        end
      end
      s_if.tlast  = (i == nb - 1);
      s_if.tvalid = 1'b1;
      cfg_shift   = (i == 0) ? c0 : c1;
      acc = 1'b0;
      for (int t = 0; t < 400 && !acc; t++) begin
        @(negedge aclk);
        acc = s_if.tready;
        @(posedge aclk);
        #1;
      end
      if (!acc) to_cnt++;
      if (i == 0) acc_first = cyc;
      acc_last = cyc;
    end
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
  endtask

  task automatic drain(input int n);
    for (int t = 0; t < 400 && got_q.size() < n; t++) begin
      @(posedge aclk);
      #1;
    end
    repeat (4) begin
      @(posedge aclk);
      #1;
    end
  endtask

  task automatic test_reset;
    ARESETn     = 1'b0;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tkeep  = '0;
    s_if.tlast  = 1'b0;
    cfg_shift   = '0;
    rand_mode   = 1'b0;
    #13;
    total++;
    if ({m_if.tvalid, m_if.tdata, m_if.tkeep, m_if.tlast, runt_drop, pkt_cnt} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got=%h/%h/%h/%b/%b/%h required all zero",
               m_if.tvalid, m_if.tdata, m_if.tkeep, m_if.tlast, runt_drop, pkt_cnt);
    end
    @(negedge aclk);
    ARESETn = 1'b1;
    @(posedge aclk);
    #1;
    total++;
    if (s_if.tready !== 1'b1) begin
      bad++;
      $display("FAIL reset_tready got=%b required=1", s_if.tready);
    end
    total++;
    if (m_if.tvalid !== 1'b0) begin
      bad++;
      $display("FAIL reset_tvalid got=%b required=0", m_if.tvalid);
    end
  endtask

  task automatic test_spec_vectors;
    logic [7:0] pk[$];
    beat_t      lit;
    int         r0;
    got_q.delete();
    exp_q.delete();
    r0 = runt_seen;
    pk.delete(); for (int i = 0; i < 12; i++) pk.push_back(8'(i));
    model_pkt(pk, 1); send_pkt(pk, 2'd1, 2'd1);
    pk.delete(); for (int i = 0; i < 6; i++) pk.push_back(8'(i));
    model_pkt(pk, 2); send_pkt(pk, 2'd2, 2'd2);
    pk.delete(); for (int i = 0; i < 3; i++) pk.push_back(8'(i));
    model_pkt(pk, 3); send_pkt(pk, 2'd3, 2'd3);
    pk.delete(); for (int i = 0; i < 4; i++) pk.push_back(8'(i));
    model_pkt(pk, 3); send_pkt(pk, 2'd3, 2'd3);
    drain(exp_q.size());
    total++;
    if (got_q.size() !== exp_q.size()) begin
      bad++;
      $display("FAIL vec_count got=%0d required=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL vec_beat%0d got=%h required=%h", i, got_q[i], exp_q[i]);
      end
    end
    lit = {32'h000B0A09, 4'h7, 1'b1};
    total++;
    if (got_q.size() < 5 || got_q[2] !== lit) begin
      bad++;
      $display("FAIL vec_flush_beat got=%h required=%h", (got_q.size() > 2) ? got_q[2] : '0, lit);
    end
    lit = {32'h05040302, 4'hF, 1'b1};
    total++;
    if (got_q.size() < 5 || got_q[3] !== lit) begin
      bad++;
      $display("FAIL vec_s2_beat got=%h required=%h", (got_q.size() > 3) ? got_q[3] : '0, lit);
    end
    lit = {32'h00000003, 4'h1, 1'b1};
    total++;
    if (got_q.size() < 5 || got_q[4] !== lit) begin
      bad++;
      $display("FAIL vec_s3_beat got=%h required=%h", (got_q.size() > 4) ? got_q[4] : '0, lit);
    end
    total++;
    if (runt_seen - r0 !== 1) begin
      bad++;
      $display("FAIL vec_runt got=%0d required=1", runt_seen - r0);
    end
    total++;
    if (pkt_cnt !== 16'(exp_cnt)) begin
      bad++;
      $display("FAIL vec_pkt_cnt got=%0d required=%0d", pkt_cnt, exp_cnt);
    end
  endtask

  task automatic test_backpressure;
    logic [7:0] pk[$];
    got_q.delete();
    exp_q.delete();
    stab_err  = 0;
    rdy_err   = 0;
    rand_mode = 1'b1;
    for (int i = 0; i < 80; i++) pk.push_back(8'($urandom));
    model_pkt(pk, 1);
    send_pkt(pk, 2'd1, 2'd1);
    drain(exp_q.size());
    rand_mode = 1'b0;
    drain(exp_q.size());
    total++;
    if (got_q.size() !== exp_q.size()) begin
      bad++;
      $display("FAIL bp_count got=%0d required=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL bp_beat%0d got=%h required=%h", i, got_q[i], exp_q[i]);
      end
    end
    total++;
    if (stab_err !== 0) begin
      bad++;
      $display("FAIL bp_stable got=%0d unstable stalls required=0", stab_err);
    end
    total++;
    if (rdy_err !== 0) begin
      bad++;
      $display("FAIL bp_tready got=%0d ready-while-stalled required=0", rdy_err);
    end
    total++;
    if (pkt_cnt !== 16'(exp_cnt)) begin
      bad++;
      $display("FAIL bp_pkt_cnt got=%0d required=%0d", pkt_cnt, exp_cnt);
    end
  endtask

  task automatic test_passthrough;
    logic [7:0]  pk[$];
    logic [31:0] w;
    got_q.delete();
    exp_q.delete();
    for (int i = 0; i < 4; i++) pk.push_back(8'($urandom));
    w = {pk[3], pk[2], pk[1], pk[0]};
    model_pkt(pk, 0);
    send_pkt(pk, 2'd0, 2'd0);
    total++;
    if (m_if.tvalid !== 1'b1 || m_if.tdata !== w) begin
      bad++;
      $display("FAIL pt_latency got vld=%b dat=%h required vld=1 dat=%h", m_if.tvalid, m_if.tdata, w);
    end
    pk.delete(); for (int i = 0; i < 10; i++) pk.push_back(8'($urandom));
    model_pkt(pk, 0); send_pkt(pk, 2'd0, 2'd2);
    pk.delete(); for (int i = 0; i < 9; i++) pk.push_back(8'($urandom));
    model_pkt(pk, 2); send_pkt(pk, 2'd2, 2'd0);
    drain(exp_q.size());
    total++;
    if (got_q.size() !== exp_q.size()) begin
      bad++;
      $display("FAIL pt_count got=%0d required=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL pt_beat%0d got=%h required=%h", i, got_q[i], exp_q[i]);
      end
    end
    total++;
    if (pkt_cnt !== 16'(exp_cnt)) begin
      bad++;
      $display("FAIL pt_pkt_cnt got=%0d required=%0d", pkt_cnt, exp_cnt);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] pk[$];
    int         a_last;
    got_q.delete();
    exp_q.delete();
    for (int i = 0; i < 12; i++) pk.push_back(8'($urandom));
    model_pkt(pk, 1);
    send_pkt(pk, 2'd1, 2'd1);
    a_last = acc_last;
    pk.delete(); for (int i = 0; i < 10; i++) pk.push_back(8'($urandom));
    model_pkt(pk, 1);
    send_pkt(pk, 2'd1, 2'd1);
    drain(exp_q.size());
    total++;
    if (acc_first - a_last !== 2) begin
      bad++;
      $display("FAIL b2b_gap got=%0d cycles required=2", acc_first - a_last);
    end
    total++;
    if (got_q.size() !== exp_q.size()) begin
      bad++;
      $display("FAIL b2b_count got=%0d required=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL b2b_beat%0d got=%h required=%h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] pk[$];
    rand_mode   = 1'b0;
    cfg_shift   = 2'd1;
    s_if.tdata  = 32'h13121110;
    s_if.tkeep  = 4'hF;
    s_if.tlast  = 1'b0;
    s_if.tvalid = 1'b1;
    @(posedge aclk); #1;
    s_if.tdata  = 32'h17161514;
    @(posedge aclk); #1;
    s_if.tvalid = 1'b0;
    @(negedge aclk); #1;
    ARESETn = 1'b0;
    #1;
    total++;
    if ({m_if.tvalid, m_if.tdata, m_if.tkeep, m_if.tlast, runt_drop, pkt_cnt} !== '0) begin
      bad++;
      $display("FAIL midrst_outputs got=%h/%h/%h/%b/%b/%h required all zero",
               m_if.tvalid, m_if.tdata, m_if.tkeep, m_if.tlast, runt_drop, pkt_cnt);
    end
    @(negedge aclk);
    ARESETn = 1'b1;
    @(posedge aclk); #1;
    got_q.delete();
    exp_q.delete();
    exp_cnt = 0;
    for (int i = 0; i < 7; i++) pk.push_back(8'($urandom));
    model_pkt(pk, 2);
    send_pkt(pk, 2'd2, 2'd2);
    drain(exp_q.size());
    total++;
    if (got_q.size() !== exp_q.size()) begin
      bad++;
      $display("FAIL midrst_count got=%0d required=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL midrst_beat%0d got=%h required=%h", i, got_q[i], exp_q[i]);
      end
    end
    total++;
    if (pkt_cnt !== 16'(exp_cnt)) begin
      bad++;
      $display("FAIL midrst_pkt_cnt got=%0d required=%0d", pkt_cnt, exp_cnt);
    end
  endtask

  initial begin
    total = 0; bad = 0; runt_seen = 0; exp_runt = 0; stab_err = 0; rdy_err = 0;
    to_cnt = 0; cyc = 0; exp_cnt = 0; stall_q = 1'b0; stall_beat = '0;
    test_reset();
    test_spec_vectors();
    test_backpressure();
    test_passthrough();
    test_back_to_back();
    test_reset_mid();
    total++;
    if (to_cnt !== 0) begin
      bad++;
      $display("FAIL input_timeouts got=%0d required=0", to_cnt);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
